// File: rtl/sram_responder.sv
// SRAM-port responder: synchronous word RAM plus an MMIO page (LED, switch, timer, compare).
// Optional timer compare interrupt is enabled by defining SRAM_RESPONDER_TIMER_IRQ_EN.
module sram_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h1faf_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [15:0]           off;
  logic                  is_mmio;
  logic                  accept;
  logic                  wr;
  logic [31:0]           wmask;
  logic [31:0]           mmio_rd;
  logic [31:0]           timer;
  logic [31:0]           timer_d;
  logic                  wr_led;
  logic                  wr_timer;

  assign idx      = addr[ADDR_WIDTH+1:2];
  assign off      = addr[15:0];
  assign is_mmio  = (addr[31:16] == MMIO_BASE[31:16]);
  assign accept   = en & ~rst;
  assign wr       = accept & (|wen);
  assign wr_led   = wr & is_mmio & (off == 16'h0000);
  assign wr_timer = wr & is_mmio & (off == 16'h0008);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wen[i]}};
  end

`ifdef SRAM_RESPONDER_TIMER_IRQ_EN
  logic [31:0] compare;
  logic        irq;
  logic        wr_cmp;

  assign wr_cmp    = wr & is_mmio & (off == 16'h000C);
  assign timer_irq = irq;

  // A COMPARE write clears the flag and wins over a same-edge match.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      irq     <= 1'b0;
    end else if (wr_cmp) begin
      compare <= (compare & ~wmask) | (wdata & wmask);
      irq     <= 1'b0;
    end else if (timer_d == compare) begin
      irq     <= 1'b1;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    mmio_rd = '0;
    case (off)
      16'h0000: mmio_rd = {16'b0, led_out};
      16'h0004: mmio_rd = {16'b0, switch_in};
      16'h0008: mmio_rd = timer;
`ifdef SRAM_RESPONDER_TIMER_IRQ_EN
      16'h000C: mmio_rd = compare;
`endif
      default:  mmio_rd = '0;
    endcase
  end

  // A timer write replaces the enabled lanes instead of incrementing on that edge.
  assign timer_d = wr_timer ? ((timer & ~wmask) | (wdata & wmask)) : (timer + 32'd1);

  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer_d;
  end

  always_ff @(posedge clk) begin
    if (rst)         led_out <= '0;
    else if (wr_led) led_out <= (led_out & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
  end

  always_ff @(posedge clk) begin
    if (wr && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read-first: rdata captures the pre-write contents of the addressed location.
  always_ff @(posedge clk) begin
    if (rst)         rdata <= '0;
    else if (accept) rdata <= is_mmio ? mmio_rd : mem[idx];
  end

endmodule
